// File: rtl/my_isolation_seq.sv
`default_nettype none
// ============================================================================
// Module   : my_isolation_seq
// Brief    : Per-channel power-domain isolation sequencer. Each channel runs
//            an ISO -> WAKE -> ACTIVE state machine with a programmable wake
//            delay. While a channel is not ACTIVE, its output is forced to
//            zero or held at the last value it passed.
// Revision : 1.0 - initial release
// ============================================================================
module my_isolation_seq #(
  parameter int ISOLATION_DATA_WIDTH = 32,
  parameter int NUM_CH               = 4,
  parameter int WAKE_CYCLES          = 3,
  parameter int HOLD_MODE            = 0
) (
  input  logic                                   iClk,
  input  logic                                   iReset,
  input  logic [NUM_CH*ISOLATION_DATA_WIDTH-1:0] iData_In,
  input  logic [NUM_CH-1:0]                      iEnable_Req,
  input  logic                                   iIsolate_All,
  output logic [NUM_CH*ISOLATION_DATA_WIDTH-1:0] oIsolated_Out,
  output logic [NUM_CH-1:0]                      oActive,
  output logic                                   oAll_Isolated
);

  localparam int c_dataW = ISOLATION_DATA_WIDTH;
  // The counter must be able to represent WAKE_CYCLES and is never narrower than one bit.
  localparam int c_cntW  = (WAKE_CYCLES == 0) ? 1 : $clog2(WAKE_CYCLES + 1);

  localparam logic [c_cntW-1:0] c_cntOne     = c_cntW'(1);
  localparam logic [c_cntW-1:0] c_wakeTarget = c_cntW'(WAKE_CYCLES);

  localparam logic [1:0] c_stIso    = 2'd0;
  localparam logic [1:0] c_stWake   = 2'd1;
  localparam logic [1:0] c_stActive = 2'd2;

  logic [NUM_CH-1:0] w_isoVec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]         r_state;
    logic [c_cntW-1:0]  r_wakeCnt;
    logic               w_go;
    logic [c_dataW-1:0] w_dataCh;
    logic [c_dataW-1:0] w_holdVal;

    // The global isolate wins over any per-channel request.
    assign w_go     = iEnable_Req[c] & ~iIsolate_All;
    assign w_dataCh = iData_In[c*c_dataW +: c_dataW];

    // Channel sequencer: a wake attempt must see the request on every
    // consecutive edge; any gap sends it back to ISO with no credit kept.
    always_ff @(posedge iClk) begin
      if (iReset) begin
        r_state   <= c_stIso;
        r_wakeCnt <= '0;
      end else begin
        case (r_state)
          c_stIso: begin
            if (w_go) begin
              if (WAKE_CYCLES == 0) begin
                r_state <= c_stActive;
              end else begin
                r_state   <= c_stWake;
                r_wakeCnt <= c_cntOne;
              end
            end
          end
          c_stWake: begin
            if (!w_go) begin
              r_state   <= c_stIso;
              r_wakeCnt <= '0;
            end else if (r_wakeCnt == c_wakeTarget) begin
              r_state   <= c_stActive;
              r_wakeCnt <= '0;
            end else begin
              r_wakeCnt <= r_wakeCnt + c_cntOne;
            end
          end
          c_stActive: begin
            if (!w_go) begin
              r_state <= c_stIso;
            end
          end
          default: begin
            r_state   <= c_stIso;
            r_wakeCnt <= '0;
          end
        endcase
      end
    end

    if (HOLD_MODE != 0) begin : g_hold
      logic [c_dataW-1:0] r_hold;

      // Track the input while ACTIVE so the last passed value survives isolation.
      always_ff @(posedge iClk) begin
        if (iReset) begin
          r_hold <= '0;
        end else if (r_state == c_stActive) begin
          r_hold <= w_dataCh;
        end
      end

      assign w_holdVal = r_hold;
    end else begin : g_noHold
      assign w_holdVal = '0;
    end

    // Zero-latency pass-through while ACTIVE; clamp value otherwise.
    assign oIsolated_Out[c*c_dataW +: c_dataW] = (r_state == c_stActive) ? w_dataCh : w_holdVal;
    assign oActive[c]  = (r_state == c_stActive);
    assign w_isoVec[c] = (r_state == c_stIso);
  end

  assign oAll_Isolated = &w_isoVec;

endmodule
`default_nettype wire

// File: tb/tb_my_isolation_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_my_isolation_seq
// Brief    : Self-checking bench for my_isolation_seq. Three instances share
//            one stimulus: A (WAKE=3, zero clamp), B (WAKE=3, hold) and
//            C (WAKE=0, hold). A streak-count model predicts all outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_isolation_seq;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int NDUT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] data;
  logic [N-1:0]   en;
  logic           isoAll;

  logic [N*W-1:0] dOut [NDUT];
  logic [N-1:0]   dAct [NDUT];
  logic           dAll [NDUT];

  always #5 clk = ~clk;

  my_isolation_seq #(.ISOLATION_DATA_WIDTH(W), .NUM_CH(N), .WAKE_CYCLES(3), .HOLD_MODE(0)) dutA (
    .iClk(clk), .iReset(rst), .iData_In(data), .iEnable_Req(en), .iIsolate_All(isoAll),
    .oIsolated_Out(dOut[0]), .oActive(dAct[0]), .oAll_Isolated(dAll[0]));

  my_isolation_seq #(.ISOLATION_DATA_WIDTH(W), .NUM_CH(N), .WAKE_CYCLES(3), .HOLD_MODE(1)) dutB (
    .iClk(clk), .iReset(rst), .iData_In(data), .iEnable_Req(en), .iIsolate_All(isoAll),
    .oIsolated_Out(dOut[1]), .oActive(dAct[1]), .oAll_Isolated(dAll[1]));

  my_isolation_seq #(.ISOLATION_DATA_WIDTH(W), .NUM_CH(N), .WAKE_CYCLES(0), .HOLD_MODE(1)) dutC (
    .iClk(clk), .iReset(rst), .iData_In(data), .iEnable_Req(en), .iIsolate_All(isoAll),
    .oIsolated_Out(dOut[2]), .oActive(dAct[2]), .oAll_Isolated(dAll[2]));

  // Model: a channel is ACTIVE once its request has been granted on at least
  // WAKE+1 consecutive edges; ISO when the streak is zero.
  int           streak [NDUT][N];
  logic [W-1:0] holdM  [NDUT][N];

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] expAct;
    logic         expAll;
  } vec_t;

  vec_t tbl [17];

  function automatic int wcOf(input int d);
    return (d == 2) ? 0 : 3;
  endfunction

  function automatic bit hmOf(input int d);
    return (d != 0);
  endfunction

  task automatic cmp(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic updateModel();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < N; c++) begin
        automatic bit wasAct = (streak[d][c] >= wcOf(d) + 1);
        if (rst) begin
          streak[d][c] = 0;
          holdM[d][c]  = '0;
        end else begin
          if (hmOf(d) && wasAct) holdM[d][c] = data[c*W +: W];
          if (en[c] && !isoAll) begin
            if (streak[d][c] < 1000) streak[d][c] = streak[d][c] + 1;
          end else begin
            streak[d][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic checkModel(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      automatic logic [N*W-1:0] expOut = '0;
      automatic logic [N-1:0]   expAct = '0;
      automatic logic           expAll = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (streak[d][c] >= wcOf(d) + 1) begin
          expAct[c]          = 1'b1;
          expOut[c*W +: W]   = data[c*W +: W];
        end else if (hmOf(d)) begin
          expOut[c*W +: W]   = holdM[d][c];
        end
        if (streak[d][c] != 0) expAll = 1'b0;
      end
      cmp($sformatf("%s dut%0d out", tag, d), dOut[d], expOut);
      cmp($sformatf("%s dut%0d active", tag, d), {{(N*W-N){1'b0}}, dAct[d]}, {{(N*W-N){1'b0}}, expAct});
      cmp($sformatf("%s dut%0d allIso", tag, d), {{(N*W-1){1'b0}}, dAll[d]}, {{(N*W-1){1'b0}}, expAll});
    end
  endtask

  // Inputs are already driven; check mid-cycle, then take one edge.
  task automatic step(input bit doCheck, input string tag);
    #2;
    if (doCheck) checkModel(tag);
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    automatic logic [N*W-1:0] tblOut;

    rst    = 1'b1;
    en     = '0;
    isoAll = 1'b0;
    data   = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < N; c++) begin
        streak[d][c] = 0;
        holdM[d][c]  = '0;
      end

    step(1'b0, "reset");
    step(1'b0, "reset");
    rst = 1'b0;

    // Reset state, all instances.
    #1;
    for (int d = 0; d < NDUT; d++) begin
      cmp($sformatf("reset out%0d", d), dOut[d], '0);
      cmp($sformatf("reset active%0d", d), {{(N*W-N){1'b0}}, dAct[d]}, '0);
      cmp($sformatf("reset allIso%0d", d), {{(N*W-1){1'b0}}, dAll[d]}, {{(N*W-1){1'b0}}, 1'b1});
    end

    // Directed wake on ch1 then aborted/re-tried wake on ch0 (instance A, WAKE=3).
    tbl[0]  = '{4'b0010, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0010, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0010, 4'b0010, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0010, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0001, 4'b0000, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 1'b0};
    tbl[12] = '{4'b0001, 4'b0000, 1'b0};
    tbl[13] = '{4'b0001, 4'b0000, 1'b0};
    tbl[14] = '{4'b0001, 4'b0001, 1'b0};
    tbl[15] = '{4'b0000, 4'b0001, 1'b0};
    tbl[16] = '{4'b0000, 4'b0000, 1'b1};

    for (int i = 0; i < 17; i++) begin
      en     = tbl[i].en;
      isoAll = 1'b0;
      #1;
      tblOut = '0;
      for (int c = 0; c < N; c++)
        if (tbl[i].expAct[c]) tblOut[c*W +: W] = data[c*W +: W];
      cmp($sformatf("tbl[%0d] active", i), {{(N*W-N){1'b0}}, dAct[0]}, {{(N*W-N){1'b0}}, tbl[i].expAct});
      cmp($sformatf("tbl[%0d] allIso", i), {{(N*W-1){1'b0}}, dAll[0]}, {{(N*W-1){1'b0}}, tbl[i].expAll});
      cmp($sformatf("tbl[%0d] out", i), dOut[0], tblOut);
      step(1'b1, "tbl");
    end

    // Hold mode: ch2 passes 0x12345678, request drops, input then goes to all ones.
    en = '0;
    step(1'b1, "holdPre");
    data[2*W +: W] = 32'h12345678;
    en = 4'b0100;
    for (int k = 0; k < 5; k++) step(1'b1, "holdWake");
    cmp("hold ch2 active", {{(N*W-1){1'b0}}, dAct[1][2]}, {{(N*W-1){1'b0}}, 1'b1});
    en = '0;
    step(1'b1, "holdDrop");
    data[2*W +: W] = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp($sformatf("hold ch2 value %0d", k), {{(N*W-W){1'b0}}, dOut[1][2*W +: W]}, {{(N*W-W){1'b0}}, 32'h12345678});
      cmp($sformatf("zero ch2 value %0d", k), {{(N*W-W){1'b0}}, dOut[0][2*W +: W]}, '0);
      step(1'b1, "holdIso");
    end

    // Global override pulse with all requests held high.
    data = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    en = 4'b1111;
    for (int k = 0; k < 5; k++) step(1'b1, "ovrWake");
    cmp("ovr all active", {{(N*W-N){1'b0}}, dAct[0]}, {{(N*W-N){1'b0}}, 4'b1111});
    isoAll = 1'b1;
    step(1'b1, "ovrPulse");
    isoAll = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++)
      cmp($sformatf("ovr allIso%0d", d), {{(N*W-1){1'b0}}, dAll[d]}, {{(N*W-1){1'b0}}, 1'b1});
    cmp("ovr active cleared", {{(N*W-N){1'b0}}, dAct[0]}, '0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, "ovrRewake");
      cmp($sformatf("ovr rewake A edge %0d", k), {{(N*W-N){1'b0}}, dAct[0]},
          {{(N*W-N){1'b0}}, (k == 4) ? 4'b1111 : 4'b0000});
      cmp($sformatf("ovr rewake C edge %0d", k), {{(N*W-N){1'b0}}, dAct[2]}, {{(N*W-N){1'b0}}, 4'b1111});
    end

    // Zero wake delay: instance C activates one edge after the request.
    en = '0;
    step(1'b1, "zlPre");
    step(1'b1, "zlPre");
    en = 4'b1000;
    #1;
    cmp("zl before edge", {{(N*W-1){1'b0}}, dAct[2][3]}, '0);
    step(1'b1, "zlEdge");
    cmp("zl after edge", {{(N*W-1){1'b0}}, dAct[2][3]}, {{(N*W-1){1'b0}}, 1'b1});

    // Reset in the middle of mixed WAKE/ACTIVE states.
    en = '0;
    step(1'b1, "mrPre");
    step(1'b1, "mrPre");
    en = 4'b0011;
    for (int k = 0; k < 5; k++) step(1'b1, "mrWake");
    en = 4'b1111;
    step(1'b1, "mrMixed");
    rst = 1'b1;
    step(1'b1, "mrReset");
    rst = 1'b0;
    en  = '0;
    #1;
    cmp("mr hold out", dOut[1], '0);
    cmp("mr hold active", {{(N*W-N){1'b0}}, dAct[1]}, '0);
    cmp("mr hold allIso", {{(N*W-1){1'b0}}, dAll[1]}, {{(N*W-1){1'b0}}, 1'b1});
    step(1'b1, "mrPost");

    // Randomized traffic with persistent request levels.
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) en[c] = ~en[c];
      isoAll = ($urandom_range(0, 24) == 0);
      rst    = ($urandom_range(0, 59) == 0);
      data   = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/my_isolation_seq.md
MY_ISOLATION_SEQ -- requirements
Module: my_isolation_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter ISOLATION_DATA_WIDTH, default 32, giving the data width per channel.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of independent isolation channels (1..16).
REQ-003 The block SHALL have parameter WAKE_CYCLES, default 3, giving the isolated-to-active release delay in cycles (0..255).
REQ-004 The block SHALL have parameter HOLD_MODE, default 0, where 0 drives isolated outputs to zero and 1 holds the last active value.

Ports:
REQ-005 The block SHALL have port iClk, input, width 1, the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port iReset, input, width 1, a synchronous active-high reset.
REQ-007 The block SHALL have port iData_In, input, width NUM_CH*ISOLATION_DATA_WIDTH, where channel c occupies bits [c*W +: W].
REQ-008 The block SHALL have port iEnable_Req, input, width NUM_CH, a per-channel level request to un-isolate.
REQ-009 The block SHALL have port iIsolate_All, input, width 1, a global force-isolate that overrides all requests.
REQ-010 The block SHALL have port oIsolated_Out, output, width NUM_CH*ISOLATION_DATA_WIDTH, using the same packing as iData_In.
REQ-011 The block SHALL have port oActive, output, width NUM_CH, asserted per channel while it is in the ACTIVE state.
REQ-012 The block SHALL have port oAll_Isolated, output, width 1, asserted when every channel is in the ISO state.

Function
REQ-013 Each channel SHALL run an independent FSM with states ISO, WAKE and ACTIVE, plus a wake counter of width max(1, clog2(WAKE_CYCLES+1)).
REQ-014 From ISO, when iEnable_Req[c]=1 and iIsolate_All=0, the channel SHALL go to WAKE with counter=1, or directly to ACTIVE when WAKE_CYCLES=0.
REQ-015 In WAKE, the counter SHALL increment each cycle, and the channel SHALL go to ACTIVE on the edge where counter==WAKE_CYCLES.
- Result: oActive[c] rises exactly WAKE_CYCLES+1 edges after the first edge sampling the request.
REQ-016 In WAKE, if iEnable_Req[c]=0 or iIsolate_All=1, the channel SHALL return to ISO with the counter cleared, and no partial credit SHALL be kept.
REQ-017 In ACTIVE, if iEnable_Req[c]=0 or iIsolate_All=1, the channel SHALL go to ISO on the next edge.
REQ-018 iIsolate_All=1 SHALL take priority over every request in the same cycle, for all channels.
REQ-019 Output gating SHALL be combinational from registered state: ACTIVE passes iData_In[c] unchanged with zero latency.
REQ-020 In ISO or WAKE with HOLD_MODE=0, the channel output SHALL be all zeros.
REQ-021 In ISO or WAKE with HOLD_MODE=1, the channel output SHALL be hold_reg[c].
REQ-022 With HOLD_MODE=1, hold_reg[c] SHALL capture iData_In[c] on every edge where the channel is ACTIVE.
- Result: it holds the value present in the last ACTIVE cycle.
REQ-023 With HOLD_MODE=0, no hold registers SHALL be instantiated.
REQ-024 oAll_Isolated SHALL equal the AND over all channels of (state==ISO), and SHALL be combinational from state.
REQ-025 Channels SHALL be fully independent: a request or state change on one channel SHALL NOT alter another channel's state or timing.

Reset
REQ-026 On an edge with iReset=1, every channel SHALL enter ISO, all counters SHALL clear to 0 and all hold_reg SHALL clear to 0.
REQ-027 Reset SHALL override all other inputs, and reset asserted mid-WAKE or mid-ACTIVE SHALL abort to ISO on that edge.
REQ-028 After reset: oActive=0, oAll_Isolated=1, and oIsolated_Out=0 in both modes.

Verification
REQ-029 Bench SHALL cover basic wake: W=32, NUM_CH=4, WAKE_CYCLES=3, HOLD_MODE=0; raise iEnable_Req[1] after reset with data 0xDEADBEEF.
- Required: oActive[1] rises on the 4th edge, ch1 output is 0 before it and 0xDEADBEEF after.
- Required: oAll_Isolated falls one edge after the request is sampled.
REQ-030 Bench SHALL cover aborted wake: drop iEnable_Req[0] on the 2nd WAKE cycle, then re-raise it.
- Required: the channel returns to ISO and needs a full 3 WAKE cycles again.
- Required: oActive[0] never pulses during the aborted wake.
REQ-031 Bench SHALL cover hold mode: HOLD_MODE=1, ch2 ACTIVE with the last data 0x12345678, then deassert the request and drive the input to 0xFFFFFFFF.
- Required: ch2 output reads 0x12345678 from the next edge onward.
REQ-032 Bench SHALL cover the global override: all channels ACTIVE, pulse iIsolate_All for 1 cycle with all requests held high.
- Required: all channels go to ISO and oAll_Isolated=1 for 1 cycle.
- Required: the channels then re-wake and oActive returns after WAKE_CYCLES+1 edges.
REQ-033 Bench SHALL cover the zero-latency case: WAKE_CYCLES=0.
- Required: oActive[c] rises 1 edge after the request is sampled.
REQ-034 Bench SHALL cover mid-operation reset: assert iReset while channels are in mixed WAKE/ACTIVE states with HOLD_MODE=1.
- Required: on the next edge all outputs are 0, oActive=0 and oAll_Isolated=1.
